// File: rtl/multi_cycle_subtractor_ctrl.sv
// Wide unsigned subtractor (a - b - b_in) computed over N_CHUNKS cycles by a single
// CHUNK-bit ripple-borrow subtractor, with valid/ready handshakes on both sides.

module full_subtractor (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    assign o_d    = i_x ^ i_y ^ i_bin;
    assign o_bout = (~i_x & i_y) | (~(i_x ^ i_y) & i_bin);
endmodule

module chunk_subtractor #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_x,
    input  logic [CHUNK-1:0] i_y,
    input  logic             i_bin,
    output logic [CHUNK-1:0] o_d,
    output logic             o_bout
);
    logic [CHUNK:0] bchain;

    assign bchain[0] = i_bin;
    assign o_bout    = bchain[CHUNK];

    for (genvar g = 0; g < CHUNK; g++) begin : g_bit
        full_subtractor u_fs (
            .i_x    (i_x[g]),
            .i_y    (i_y[g]),
            .i_bin  (bchain[g]),
            .o_d    (o_d[g]),
            .o_bout (bchain[g+1])
        );
    end
endmodule

module multi_cycle_subtractor_ctrl #(
    parameter int CHUNK    = 4,
    parameter int N_CHUNKS = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [CHUNK*N_CHUNKS-1:0] i_a,
    input  logic [CHUNK*N_CHUNKS-1:0] i_b,
    input  logic                      i_b_in,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [CHUNK*N_CHUNKS-1:0] o_d,
    output logic                      o_b_out,
    output logic                      o_zero
);
    localparam int WIDTH = CHUNK * N_CHUNKS;
    localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK-1:0]   diff_chunk;
    logic               borrow_out;

    // The only subtractor in the design; the counter selects which slice it sees.
    always_comb begin
        a_chunk = a_q[cnt_q*CHUNK +: CHUNK];
        b_chunk = b_q[cnt_q*CHUNK +: CHUNK];
    end

    chunk_subtractor #(.CHUNK(CHUNK)) u_sub (
        .i_x    (a_chunk),
        .i_y    (b_chunk),
        .i_bin  (borrow_q),
        .o_d    (diff_chunk),
        .o_bout (borrow_out)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        a_d      = a_q;
        b_d      = b_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    a_d      = i_a;
                    b_d      = i_b;
                    borrow_d = i_b_in;
                    cnt_d    = '0;
                    d_d      = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                d_d[cnt_q*CHUNK +: CHUNK] = diff_chunk;
                borrow_d = borrow_out;
                if (cnt_q == CNT_W'(N_CHUNKS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result and borrow are reset too, since the outputs must read zero after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
        end
    end

    always_ff @(posedge i_clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign o_ready = (state_q == S_IDLE);
    assign o_valid = (state_q == S_DONE);
    assign o_d     = d_q;
    assign o_b_out = borrow_q;
    assign o_zero  = (d_q == '0);
endmodule

// File: tb/tb_multi_cycle_subtractor_ctrl.sv
// Directed bench for multi_cycle_subtractor_ctrl: a 4x4 instance and a 4x1 instance.

module tb_multi_cycle_subtractor_ctrl;
    logic        clk;
    logic        rst;

    logic        v4, rdy_o4, bin4, vo4, rdy_i4, bo4, z4;
    logic [15:0] a4, b4, d4;

    logic        v1, rdy_o1, bin1, vo1, rdy_i1, bo1, z1;
    logic [3:0]  a1, b1, d1;

    int errors = 0;
    int checks = 0;

    multi_cycle_subtractor_ctrl #(.CHUNK(4), .N_CHUNKS(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(rdy_o4),
        .i_a(a4), .i_b(b4), .i_b_in(bin4), .o_valid(vo4), .i_ready(rdy_i4),
        .o_d(d4), .o_b_out(bo4), .o_zero(z4)
    );

    multi_cycle_subtractor_ctrl #(.CHUNK(4), .N_CHUNKS(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(rdy_o1),
        .i_a(a1), .i_b(b1), .i_b_in(bin1), .o_valid(vo1), .i_ready(rdy_i1),
        .o_d(d1), .o_b_out(bo1), .o_zero(z1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, input logic [15:0] exp_d,
                          input logic exp_bo, input logic exp_z);
        int n;
        chk({tag, "_ready_before"}, 32'(rdy_o4), 32'd1);
        v4 = 1'b1; a4 = a; b4 = b; bin4 = bin;
        tick();
        v4 = 1'b0; a4 = 16'hDEAD; b4 = 16'hBEEF; bin4 = 1'b1;
        chk({tag, "_ready_run"}, 32'(rdy_o4), 32'd0);
        n = 0;
        while (!vo4 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_d"}, 32'(d4), 32'(exp_d));
        chk({tag, "_bout"}, 32'(bo4), 32'(exp_bo));
        chk({tag, "_zero"}, 32'(z4), 32'(exp_z));
        rdy_i4 = 1'b1;
        tick();
        rdy_i4 = 1'b0;
        chk({tag, "_valid_drop"}, 32'(vo4), 32'd0);
        chk({tag, "_ready_after"}, 32'(rdy_o4), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        v4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0; rdy_i4 = 1'b0;
        v1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0; rdy_i1 = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_ready", 32'(rdy_o4), 32'd1);
        chk("rst_valid", 32'(vo4), 32'd0);
        chk("rst_d", 32'(d4), 32'd0);
        chk("rst_bout", 32'(bo4), 32'd0);
        chk("rst_zero", 32'(z4), 32'd1);

        run_op("basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("ripple1", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("ripple2", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("zero",    16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1);

        // Backpressure: held result, ignored request, then deferred accept.
        v4 = 1'b1; a4 = 16'h8000; b4 = 16'h0001; bin4 = 1'b0;
        tick();
        v4 = 1'b0;
        n = 0;
        while (!vo4 && n < 20) begin
            tick();
            n++;
        end
        chk("bp_latency", 32'(n), 32'd4);
        v4 = 1'b1; a4 = 16'h0003; b4 = 16'h0005; bin4 = 1'b0; rdy_i4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(vo4), 32'd1);
            chk("bp_d", 32'(d4), 32'h7FFF);
            chk("bp_bout", 32'(bo4), 32'd0);
            chk("bp_ready", 32'(rdy_o4), 32'd0);
        end
        rdy_i4 = 1'b1;
        tick();
        rdy_i4 = 1'b0;
        chk("bp_idle_valid", 32'(vo4), 32'd0);
        chk("bp_idle_ready", 32'(rdy_o4), 32'd1);
        tick();
        v4 = 1'b0;
        chk("bp_accepted", 32'(rdy_o4), 32'd0);
        n = 0;
        while (!vo4 && n < 20) begin
            tick();
            n++;
        end
        chk("bp2_latency", 32'(n), 32'd4);
        chk("bp2_d", 32'(d4), 32'hFFFE);
        chk("bp2_bout", 32'(bo4), 32'd1);
        rdy_i4 = 1'b1;
        tick();
        rdy_i4 = 1'b0;

        // Reset while in RUN with cnt=2, colliding with valid and ready.
        v4 = 1'b1; a4 = 16'h1234; b4 = 16'h0001; bin4 = 1'b0;
        tick();
        v4 = 1'b0;
        tick();
        tick();
        rst = 1'b1; v4 = 1'b1; rdy_i4 = 1'b1;
        tick();
        rst = 1'b0; v4 = 1'b0; rdy_i4 = 1'b0;
        chk("mrst_ready", 32'(rdy_o4), 32'd1);
        chk("mrst_valid", 32'(vo4), 32'd0);
        chk("mrst_d", 32'(d4), 32'd0);
        chk("mrst_zero", 32'(z4), 32'd1);
        tick();
        tick();
        chk("mrst_stay_idle", 32'(rdy_o4), 32'd1);
        run_op("post_rst", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0);

        // Degenerate N_CHUNKS=1 with i_ready tied high.
        chk("n1_ready0", 32'(rdy_o1), 32'd1);
        v1 = 1'b1; a1 = 4'h3; b1 = 4'h5; bin1 = 1'b0;
        tick();
        a1 = 4'h7; b1 = 4'h2;
        chk("n1_run_ready", 32'(rdy_o1), 32'd0);
        chk("n1_run_valid", 32'(vo1), 32'd0);
        tick();
        chk("n1_valid", 32'(vo1), 32'd1);
        chk("n1_d", 32'(d1), 32'hE);
        chk("n1_bout", 32'(bo1), 32'd1);
        chk("n1_zero", 32'(z1), 32'd0);
        tick();
        chk("n1_hs_valid", 32'(vo1), 32'd0);
        chk("n1_hs_ready", 32'(rdy_o1), 32'd1);
        tick();
        chk("n1_second_accept", 32'(rdy_o1), 32'd0);
        v1 = 1'b0;
        tick();
        chk("n1_valid2", 32'(vo1), 32'd1);
        chk("n1_d2", 32'(d1), 32'h5);
        chk("n1_bout2", 32'(bo1), 32'd0);
        tick();
        chk("n1_idle_end", 32'(rdy_o1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_cycle_subtractor_ctrl.md
# multi_cycle_subtractor_ctrl

Sequencing controller that performs a WIDTH-bit subtraction (a − b − b_in) over N_CHUNKS clock cycles. It reuses a single CHUNK-bit ripple-borrow subtractor, built internally from full_subtractor cells, and registers the borrow between chunks. It sits between a valid/ready producer and consumer. Designs use it wherever a wide subtract is needed but one full-width ripple path would miss timing or cost too much area.

## Interface
- CHUNK, default 4: bits per subtractor pass; must be ≥1.
- N_CHUNKS, default 4: number of passes; must be ≥1. The operand width is WIDTH = CHUNK*N_CHUNKS.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset; one clock; reset is synchronous and active-high.
- i_valid  in  1  operand request.
- o_ready  out  1  controller idle; operands are accepted when i_valid && o_ready.
- i_a  in  WIDTH  minuend.
- i_b  in  WIDTH  subtrahend.
- i_b_in  in  1  initial borrow-in.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result when o_valid && i_ready.
- o_d  out  WIDTH  difference, modulo 2^WIDTH.
- o_b_out  out  1  final borrow-out; 1 means a < b + b_in, unsigned.
- o_zero  out  1  o_d == 0.

## Operation
- State machine: IDLE → RUN → DONE → IDLE.
- IDLE:
  - o_ready=1.
  - On handshake: capture i_a, i_b into a_reg, b_reg; set borrow_reg=i_b_in; clear cnt to 0 and d_reg to 0; go to RUN.
- RUN:
  - o_ready=0; each cycle processes chunk k=cnt.
  - Datapath: a_reg[k*CHUNK +: CHUNK] − b_reg[k*CHUNK +: CHUNK] − borrow_reg, through the shared CHUNK-bit subtractor.
  - Write the difference into d_reg[k*CHUNK +: CHUNK]. The borrow-out of the top chunk bit is written to borrow_reg.
  - If cnt == N_CHUNKS−1, go to DONE. Otherwise cnt+1.
- DONE:
  - o_valid=1. o_d=d_reg, o_b_out=borrow_reg, o_zero=(d_reg==0) are held stable.
  - On i_ready, go to IDLE. o_valid drops the next cycle.
- The counter is max(1,$clog2(N_CHUNKS)) bits wide and never wraps: exit happens at N_CHUNKS−1.
- i_valid outside IDLE is ignored. Operands are not queued, and the captured registers are not disturbed.
- Input changes on i_a, i_b, i_b_in after capture have no effect.
- Exactly one subtractor instance of CHUNK bits; no WIDTH-bit subtractor exists.
- N_CHUNKS=1 degenerates to a single RUN cycle; the same rules apply.

## Timing
- Reset values:
  - state=IDLE, so o_ready=1.
  - o_valid=0, o_d=0, o_b_out=0, o_zero=1 (derived from d_reg=0).
  - cnt=0, borrow_reg=0.
- Latency: with acceptance at edge E0, chunks are written at E1..E_N. o_valid is high in the cycle after E_N, i.e. N_CHUNKS cycles after the accept edge.
- o_valid stays high and the outputs stay stable for any number of i_ready-low cycles.
- Output handshake at edge E_H: state=IDLE and o_ready=1 after E_H. The next accept is possible at E_H+1.
- Minimum initiation interval: N_CHUNKS+2 cycles.
- i_rst in any state, including mid-RUN or DONE with i_ready low:
  - Next cycle holds full reset values; the partial result is discarded.
  - i_rst has priority over simultaneous i_valid or i_ready.
- All outputs are registered or derived only from registers. There are no combinational paths from inputs to outputs.

## Test plan
- Basic subtract (CHUNK=4, N_CHUNKS=4): a=0x1234, b=0x0234, b_in=0 → d=0x1000, b_out=0, zero=0. o_valid rises exactly 4 cycles after accept.
- Full borrow ripple: a=0x0000, b=0x0001, b_in=0 → d=0xFFFF, b_out=1. Also a=0x0000, b=0x0000, b_in=1 → d=0xFFFF, b_out=1.
- Zero flag with borrow-in: a=0x5555, b=0x5554, b_in=1 → d=0x0000, zero=1, b_out=0.
- Backpressure and ignored requests:
  - Hold i_ready=0 for 5 cycles in DONE while driving i_valid=1 with new operands.
  - Required: o_valid, o_d, o_b_out stable; o_ready=0; new operands ignored.
  - After i_ready=1, those operands are accepted on the following IDLE cycle.
- Reset mid-operation: assert i_rst for one cycle while in RUN with cnt=2.
  - Next cycle: o_ready=1, o_valid=0, o_d=0.
  - A following a=0xFFFF, b=0x0001 → d=0xFFFE, b_out=0.
- Degenerate config (CHUNK=4, N_CHUNKS=1): a=0x3, b=0x5, b_in=0 → d=0xE, b_out=1, latency 1 cycle. Back-to-back requests with i_ready=1 tied show an initiation interval of 3 cycles.
